// File: rtl/sap_pkg.sv
// SAP-1 controller shared definitions: opcodes, CON word layout, T-state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sap_pkg;

  // Opcode encodings (IR upper nibble); everything else decodes as NOP
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // CON bit positions
  localparam int CON_CP = 11;
  localparam int CON_EP = 10;
  localparam int CON_LM = 9;
  localparam int CON_CE = 8;
  localparam int CON_LI = 7;
  localparam int CON_EI = 6;
  localparam int CON_LA = 5;
  localparam int CON_EA = 4;
  localparam int CON_SU = 3;
  localparam int CON_EU = 2;
  localparam int CON_LB = 1;
  localparam int CON_LO = 0;

  // Load/increment strobes: these act at the closing clock edge, so they are
  // only allowed out in a cycle where the T-state actually advances.
  localparam logic [11:0] CON_STROBE_MASK = (12'd1 << CON_CP) | (12'd1 << CON_LM) |
                                            (12'd1 << CON_LI) | (12'd1 << CON_LA) |
                                            (12'd1 << CON_LB) | (12'd1 << CON_LO);

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } con_t;

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    T6   = 3'd5,
    HALT = 3'd6
  } tstate_t;

endpackage

// File: rtl/sap_controller_if.sv
// Controller-side signal bundle: opcode/run/step in, CON word and T-state status out.
// Latency: n/a (wires only).
// Backpressure: none; step/run pace the sequencer directly.
interface sap_controller_if;
  logic [3:0]  opcode;
  logic        run;
  logic        step;
  logic [11:0] ctrl;
  logic [5:0]  t_state;
  logic        halted;

  // master: front panel / datapath side that supplies opcode and run/step
  modport master (output opcode, run, step, input ctrl, t_state, halted);
  // slave: the controller-sequencer
  modport slave  (input opcode, run, step, output ctrl, t_state, halted);
endinterface

// File: rtl/sap_ring_counter.sv
// T-state ring T1..T6 with absorbing HALT, plus step rising-edge detector.
// Latency: state advances at the clock edge of any cycle with adv_o high.
// Backpressure: state holds while adv_o is low (single-step mode, no step edge).
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run_i,
  input  logic       step_i,
  input  logic       is_hlt_i,
  output logic       adv_o,
  output tstate_t    state_o,
  output logic [5:0] t_state_o,
  output logic       halted_o
);

  tstate_t state_q, state_d;
  logic    step_q;

  // Advance every cycle in run mode, else only on the first cycle step reads high
  assign adv_o = run_i | (step_i & ~step_q);

  // Registered copy of step for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) step_q <= 1'b0;
    else          step_q <= step_i;
  end

  // Next T-state; HLT leaves the ring at the end of T4 and never returns
  always_comb begin
    state_d = state_q;
    if (adv_o) begin
      case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        T3:      state_d = T4;
        T4:      state_d = is_hlt_i ? HALT : T5;
        T5:      state_d = T6;
        T6:      state_d = T1;
        default: state_d = HALT;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= T1;
    else          state_q <= state_d;
  end

  // One-hot view of the ring; all zero in HALT
  always_comb begin
    t_state_o = 6'b000000;
    case (state_q)
      T1:      t_state_o = 6'b000001;
      T2:      t_state_o = 6'b000010;
      T3:      t_state_o = 6'b000100;
      T4:      t_state_o = 6'b001000;
      T5:      t_state_o = 6'b010000;
      T6:      t_state_o = 6'b100000;
      default: t_state_o = 6'b000000;
    endcase
  end

  assign halted_o = (state_q == HALT);
  assign state_o  = state_q;

endmodule

// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: decodes T-state and opcode into the 12-bit CON word.
// Latency: ctrl is combinational from state, opcode and adv; state steps per adv edge.
// Backpressure: load/increment strobes are suppressed in any cycle the state holds.
module sap_controller
  import sap_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  sap_controller_if.slave  bus
);

  tstate_t     state;
  logic        adv;
  con_t        con_dec;
  logic [11:0] con_gated;

  sap_ring_counter u_ring (
    .clk       (clk),
    .reset_n   (reset_n),
    .run_i     (bus.run),
    .step_i    (bus.step),
    .is_hlt_i  (bus.opcode == OP_HLT),
    .adv_o     (adv),
    .state_o   (state),
    .t_state_o (bus.t_state),
    .halted_o  (bus.halted)
  );

  // CON decode: fixed fetch in T1-T3, opcode-driven execute in T4-T6
  always_comb begin
    con_dec = '0;
    case (state)
      T1: begin
        con_dec.ep = 1'b1;
        con_dec.lm = 1'b1;
      end
      T2: con_dec.cp = 1'b1;
      T3: begin
        con_dec.ce = 1'b1;
        con_dec.li = 1'b1;
      end
      T4: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            con_dec.ei = 1'b1;
            con_dec.lm = 1'b1;
          end
          OP_OUT: begin
            con_dec.ea = 1'b1;
            con_dec.lo = 1'b1;
          end
          default: con_dec = '0;
        endcase
      end
      T5: begin
        case (bus.opcode)
          OP_LDA: begin
            con_dec.ce = 1'b1;
            con_dec.la = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            con_dec.ce = 1'b1;
            con_dec.lb = 1'b1;
          end
          default: con_dec = '0;
        endcase
      end
      T6: begin
        case (bus.opcode)
          OP_ADD: begin
            con_dec.eu = 1'b1;
            con_dec.la = 1'b1;
          end
          OP_SUB: begin
            con_dec.su = 1'b1;
            con_dec.eu = 1'b1;
            con_dec.la = 1'b1;
          end
          default: con_dec = '0;
        endcase
      end
      default: con_dec = '0;
    endcase
  end

  // Strip load/increment strobes on held cycles so a parked step never double-loads
  assign con_gated = adv ? con_dec : (con_dec & ~CON_STROBE_MASK);

  // Force a quiet control word while reset is asserted
  assign bus.ctrl = reset_n ? con_gated : 12'h000;

endmodule

// File: tb/tb_sap_controller.sv
module tb_sap_controller;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  sap_controller_if bus_if ();

  sap_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset for two cycles, release on a falling edge; time is left at that edge.
  task automatic apply_reset(input logic run_v, input logic [3:0] op_v);
    reset_n       = 1'b0;
    bus_if.run    = run_v;
    bus_if.step   = 1'b0;
    bus_if.opcode = op_v;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n       = 1'b0;
    bus_if.run    = 1'b1;
    bus_if.step   = 1'b0;
    bus_if.opcode = 4'h0;
    #1;
    tests_run++;
    if (bus_if.t_state !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_tstate: got %b expected 000001", bus_if.t_state);
    end
    tests_run++;
    if (bus_if.ctrl !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %h expected 000", bus_if.ctrl);
    end
    tests_run++;
    if (bus_if.halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_halted: got %b expected 0", bus_if.halted);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus_if.t_state !== 6'b000001 || bus_if.ctrl !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_hold: tstate %b ctrl %h expected 000001 000", bus_if.t_state, bus_if.ctrl);
    end
  endtask

  task automatic test_lda_run;
    logic [11:0] exp_seq [6];
    exp_seq = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};
    apply_reset(1'b1, 4'h0);
    for (int i = 0; i < 12; i++) begin
      #1;
      tests_run++;
      if (bus_if.ctrl !== exp_seq[i % 6]) begin
        tests_failed++;
        $display("FAIL lda_cycle%0d: got %h expected %h", i, bus_if.ctrl, exp_seq[i % 6]);
      end
      tests_run++;
      if (bus_if.t_state !== (6'b000001 << (i % 6))) begin
        tests_failed++;
        $display("FAIL lda_tstate%0d: got %b expected %b", i, bus_if.t_state, 6'b000001 << (i % 6));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_add_sub;
    logic [11:0] exp_add [6];
    logic [11:0] exp_sub [6];
    exp_add = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024};
    exp_sub = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h02C};
    apply_reset(1'b1, 4'h1);
    for (int i = 0; i < 12; i++) begin
      bus_if.opcode = (i < 6) ? 4'h1 : 4'h2;
      #1;
      tests_run++;
      if (i < 6 && bus_if.ctrl !== exp_add[i]) begin
        tests_failed++;
        $display("FAIL add_cycle%0d: got %h expected %h", i, bus_if.ctrl, exp_add[i]);
      end else if (i >= 6 && bus_if.ctrl !== exp_sub[i - 6]) begin
        tests_failed++;
        $display("FAIL sub_cycle%0d: got %h expected %h", i - 6, bus_if.ctrl, exp_sub[i - 6]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_out_hlt;
    logic [11:0] exp_out [6];
    logic [11:0] exp_hlt [4];
    exp_out = '{12'h600, 12'h800, 12'h180, 12'h011, 12'h000, 12'h000};
    exp_hlt = '{12'h600, 12'h800, 12'h180, 12'h000};
    apply_reset(1'b1, 4'hE);
    for (int i = 0; i < 6; i++) begin
      #1;
      tests_run++;
      if (bus_if.ctrl !== exp_out[i]) begin
        tests_failed++;
        $display("FAIL out_cycle%0d: got %h expected %h", i, bus_if.ctrl, exp_out[i]);
      end
      @(negedge clk);
    end
    bus_if.opcode = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (bus_if.ctrl !== exp_hlt[i] || bus_if.halted !== 1'b0) begin
        tests_failed++;
        $display("FAIL hlt_cycle%0d: ctrl %h halted %b expected %h 0", i, bus_if.ctrl, bus_if.halted, exp_hlt[i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 22; i++) begin
      #1;
      tests_run++;
      if (bus_if.halted !== 1'b1 || bus_if.t_state !== 6'b000000 || bus_if.ctrl !== 12'h000) begin
        tests_failed++;
        $display("FAIL halted_cycle%0d: halted %b tstate %b ctrl %h expected 1 000000 000",
                 i, bus_if.halted, bus_if.t_state, bus_if.ctrl);
      end
      // opcode wiggle must not wake the halted sequencer
      bus_if.opcode = 4'(i);
      @(negedge clk);
    end
    #3;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.t_state !== 6'b000001 || bus_if.halted !== 1'b0 || bus_if.ctrl !== 12'h000) begin
      tests_failed++;
      $display("FAIL halt_reset: tstate %b halted %b ctrl %h expected 000001 0 000",
               bus_if.t_state, bus_if.halted, bus_if.ctrl);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_step;
    logic [11:0] exp_first [3];
    logic [11:0] exp_hold  [3];
    int          cp_cycles;
    exp_first = '{12'h600, 12'h800, 12'h180};
    exp_hold  = '{12'h000, 12'h100, 12'h040};
    cp_cycles = 0;
    apply_reset(1'b0, 4'h0);
    #1;
    tests_run++;
    if (bus_if.ctrl !== 12'h400) begin
      tests_failed++;
      $display("FAIL step_idle: got %h expected 400", bus_if.ctrl);
    end
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 7; c++) begin
        bus_if.step = (c < 5);
        #1;
        if (bus_if.ctrl[11]) cp_cycles++;
        tests_run++;
        if (c == 0 && bus_if.ctrl !== exp_first[p]) begin
          tests_failed++;
          $display("FAIL step_p%0d_edge: got %h expected %h", p, bus_if.ctrl, exp_first[p]);
        end else if (c != 0 && bus_if.ctrl !== exp_hold[p]) begin
          tests_failed++;
          $display("FAIL step_p%0d_hold%0d: got %h expected %h", p, c, bus_if.ctrl, exp_hold[p]);
        end
        @(negedge clk);
      end
    end
    tests_run++;
    if (bus_if.t_state !== 6'b001000) begin
      tests_failed++;
      $display("FAIL step_final_tstate: got %b expected 001000", bus_if.t_state);
    end
    tests_run++;
    if (cp_cycles != 1) begin
      tests_failed++;
      $display("FAIL step_cp_count: got %0d expected 1", cp_cycles);
    end
    bus_if.run = 1'b1;
    #1;
    tests_run++;
    if (bus_if.ctrl !== 12'h240) begin
      tests_failed++;
      $display("FAIL resume_t4: got %h expected 240", bus_if.ctrl);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus_if.ctrl !== 12'h120) begin
      tests_failed++;
      $display("FAIL resume_t5: got %h expected 120", bus_if.ctrl);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    apply_reset(1'b1, 4'h1);
    repeat (4) @(negedge clk);
    #1;
    tests_run++;
    if (bus_if.ctrl !== 12'h102) begin
      tests_failed++;
      $display("FAIL mid_pre_t5: got %h expected 102", bus_if.ctrl);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.ctrl !== 12'h000 || bus_if.t_state !== 6'b000001) begin
      tests_failed++;
      $display("FAIL mid_async: ctrl %h tstate %b expected 000 000001", bus_if.ctrl, bus_if.t_state);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus_if.ctrl !== 12'h000) begin
      tests_failed++;
      $display("FAIL mid_during: got %h expected 000", bus_if.ctrl);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (bus_if.ctrl !== 12'h600 || bus_if.t_state !== 6'b000001) begin
      tests_failed++;
      $display("FAIL mid_release: ctrl %h tstate %b expected 600 000001", bus_if.ctrl, bus_if.t_state);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int          st;
    logic        step_prev;
    logic        adv;
    logic [11:0] c;
    apply_reset(1'b0, 4'h3);
    st        = 0;
    step_prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus_if.run  = ($urandom_range(0, 3) == 0);
      bus_if.step = 1'($urandom_range(0, 1));
      if (st == 0) bus_if.opcode = 4'($urandom_range(0, 14));
      #1;
      c = bus_if.ctrl;
      tests_run++;
      if ($countones({c[10], c[8], c[6], c[4], c[2]}) > 1) begin
        tests_failed++;
        $display("FAIL rand_bus%0d: ctrl %h has multiple bus drivers", i, c);
      end
      tests_run++;
      if (bus_if.t_state !== (6'b000001 << st)) begin
        tests_failed++;
        $display("FAIL rand_tstate%0d: got %b expected %b", i, bus_if.t_state, 6'b000001 << st);
      end
      if (st >= 3 && bus_if.opcode >= 4'h3 && bus_if.opcode <= 4'hD) begin
        tests_run++;
        if (c !== 12'h000) begin
          tests_failed++;
          $display("FAIL rand_nop%0d: opcode %h ctrl %h expected 000", i, bus_if.opcode, c);
        end
      end
      adv       = bus_if.run | (bus_if.step & ~step_prev);
      step_prev = bus_if.step;
      if (adv) st = (st + 1) % 6;
      @(negedge clk);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset_n       = 1'b0;
    bus_if.run    = 1'b0;
    bus_if.step   = 1'b0;
    bus_if.opcode = 4'h0;
    test_reset();
    test_lda_run();
    test_add_sub();
    test_out_hlt();
    test_step();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
